// File: rtl/mux_pkg.sv
// Shared constants for the N:1 arbitrating mux.
//   MODE_* : encodings of the 2-bit mode input
//   sw_width(n) : width of a channel index field, max(1, clog2(n))
package mux_pkg;

  localparam logic [1:0] MODE_SEL  = 2'b00;
  localparam logic [1:0] MODE_PRI  = 2'b01;
  localparam logic [1:0] MODE_RR   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  function automatic int sw_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Searches req starting at index ptr and wrapping modulo N. With ptr=0 it
// is a plain lowest-index priority encoder.
//   req     [N-1:0]  request vector
//   ptr     [SW-1:0] first index to consider (must be < N)
//   gnt_idx [SW-1:0] granted index (0 when nothing requests)
//   gnt_any          at least one request present
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = sw_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  int  hi_idx;
  int  lo_idx;
  logic hi_found;

  // Scan downward so the lowest matching index is the one that sticks.
  // hi_* tracks the lowest requester at or above ptr; lo_* the lowest
  // overall, used when the search wraps past N-1.
  always_comb begin
    hi_idx   = 0;
    lo_idx   = 0;
    hi_found = 1'b0;
    gnt_any  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_any = 1'b1;
        lo_idx  = i;
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = i;
        end
      end
    end
    gnt_idx = hi_found ? SW'(hi_idx) : SW'(lo_idx);
  end

endmodule

// File: rtl/mux_nx1_arb.sv
// N:1 multiplexer with selectable arbitration and a single registered
// output word (valid/ready on both sides, 1 word/cycle throughput).
//   clk, rst              clock, synchronous active-high reset
//   in_data  [N*W-1:0]    channel i at [i*W +: W]
//   in_valid [N-1:0]      per-channel valid
//   in_ready [N-1:0]      per-channel ready, one-hot or zero
//   sel      [SW-1:0]     channel select for MODE_SEL
//   mode     [1:0]        SEL / PRI / RR (11 behaves as PRI)
//   out_data [W-1:0]      registered word
//   out_valid             out_data/out_chan hold a word
//   out_ready             downstream accepts the word
//   out_chan [SW-1:0]     source channel of out_data
module mux_nx1_arb
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = sw_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  input  logic [1:0]     mode,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_chan
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] arb_ptr;
  logic [SW-1:0] arb_idx;
  logic          arb_any;
  logic          sel_hit;
  logic          load;
  logic          cand;
  logic          xfer;
  logic [SW-1:0] g;
  logic [W-1:0]  g_data;

  // One arbiter serves both PRI (pointer pinned to 0) and RR.
  assign arb_ptr = (mode == MODE_RR) ? ptr : '0;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (arb_ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign load = !out_valid || out_ready;

  // Decoded compare rather than in_valid[sel] so out-of-range sel values
  // (non-power-of-2 N) simply never match.
  always_comb begin
    sel_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i) && in_valid[i]) sel_hit = 1'b1;
    end
  end

  always_comb begin
    g    = arb_idx;
    cand = arb_any;
    if (mode == MODE_SEL) begin
      g    = sel;
      cand = sel_hit;
    end
  end

  assign xfer = !rst && load && cand;

  always_comb begin
    in_ready = '0;
    g_data   = '0;
    for (int i = 0; i < N; i++) begin
      if (g == SW'(i)) begin
        in_ready[i] = xfer;
        g_data      = in_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_chan  <= g;
      if (mode == MODE_RR) begin
        ptr <= (g == SW'(N - 1)) ? '0 : g + 1'b1;
      end
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Directed table-driven bench for mux_nx1_arb at N=4, W=8.
module tb_mux_nx1_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic [1:0]     mode;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_chan;

  always #5 clk = ~clk;

  mux_nx1_arb #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  typedef struct {
    logic          rst;
    logic [1:0]    mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  valid;
    logic          ordy;
    logic [N-1:0]  exp_ready;
    logic          exp_ov;
    logic [W-1:0]  exp_data;
    logic [SW-1:0] exp_chan;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic r, input logic [1:0] m, input logic [SW-1:0] s,
                     input logic [N-1:0] v, input logic o, input logic [N-1:0] er,
                     input logic eov, input logic [W-1:0] ed, input logic [SW-1:0] ec);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = s; t.valid = v; t.ordy = o;
    t.exp_ready = er; t.exp_ov = eov; t.exp_data = ed; t.exp_chan = ec;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [1:0] m, input logic [SW-1:0] s,
                       input logic [N-1:0] v, input logic o);
    @(negedge clk);
    rst = r; mode = m; sel = s; in_valid = v; out_ready = o;
    #1;
  endtask

  initial begin
    // ch3..ch0 = 44, A5, 22, 11
    in_data   = 32'h44A5_2211;
    rst = 1'b1; mode = 2'b00; sel = '0; in_valid = '0; out_ready = 1'b0;

    //   rst mode  sel valid   ordy ready   ov  data   chan
    add(1, 2'b00, 0, 4'b0000, 1, 4'b0000, 0, 8'h00, 0);  // reset state
    add(0, 2'b00, 2, 4'b0100, 1, 4'b0100, 1, 8'hA5, 2);  // SEL ch2
    add(0, 2'b01, 0, 4'b1010, 1, 4'b0010, 1, 8'h22, 1);  // PRI picks ch1
    add(0, 2'b01, 0, 4'b1010, 1, 4'b0010, 1, 8'h22, 1);
    add(0, 2'b10, 0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0);  // RR 0,1,2,3,0
    add(0, 2'b10, 0, 4'b1111, 1, 4'b0010, 1, 8'h22, 1);
    add(0, 2'b10, 0, 4'b1111, 1, 4'b0100, 1, 8'hA5, 2);
    add(0, 2'b10, 0, 4'b1111, 1, 4'b1000, 1, 8'h44, 3);
    add(0, 2'b10, 0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0);  // ptr now 1
    add(0, 2'b00, 1, 4'b0010, 0, 4'b0000, 1, 8'h11, 0);  // backpressure x3
    add(0, 2'b01, 1, 4'b0011, 0, 4'b0000, 1, 8'h11, 0);  // mode change held
    add(0, 2'b10, 1, 4'b1111, 0, 4'b0000, 1, 8'h11, 0);
    add(0, 2'b00, 1, 4'b0010, 1, 4'b0010, 1, 8'h22, 1);  // release: ch1 loads
    add(0, 2'b00, 1, 4'b0001, 1, 4'b0000, 0, 8'h22, 1);  // SEL misses: drain
    add(0, 2'b00, 1, 4'b0001, 1, 4'b0000, 0, 8'h22, 1);
    add(0, 2'b10, 0, 4'b0010, 1, 4'b0010, 1, 8'h22, 1);  // RR ch1, ptr->2
    add(1, 2'b10, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0);  // rst mid-word
    add(0, 2'b10, 0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0);  // RR from ch0, ptr->1
    add(0, 2'b11, 0, 4'b1100, 1, 4'b0100, 1, 8'hA5, 2);  // mode 11 = PRI
    add(0, 2'b10, 0, 4'b1111, 1, 4'b0010, 1, 8'h22, 1);  // ptr untouched by 11

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].ordy);
      n_vec++;
      check("in_ready", i, 32'(in_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      check("out_valid", i, 32'(out_valid), 32'(vecs[i].exp_ov));
      check("out_data",  i, 32'(out_data),  32'(vecs[i].exp_data));
      check("out_chan",  i, 32'(out_chan),  32'(vecs[i].exp_chan));
    end

    // PRI with ch1 and ch3 held valid: ch3 must never win.
    for (int k = 0; k < 5; k++) begin
      apply(0, 2'b01, 0, 4'b1010, 1);
      n_vec++;
      check("pri_no_ch3", 100 + k, 32'(in_ready), 32'h2);
      @(posedge clk);
      #1;
      check("pri_chan", 100 + k, 32'(out_chan), 32'd1);
    end

    // Reset then transfer in the very first cycle afterwards.
    apply(1, 2'b00, 3, 4'b1000, 1);
    n_vec++;
    check("rst_ready", 200, 32'(in_ready), 32'h0);
    @(posedge clk);
    apply(0, 2'b00, 3, 4'b1000, 0);
    n_vec++;
    check("post_rst_ready", 201, 32'(in_ready), 32'h8);
    @(posedge clk);
    #1;
    check("post_rst_data", 201, 32'(out_data), 32'h44);
    check("post_rst_ov", 201, 32'(out_valid), 32'h1);
    // Downstream stalled: second word blocked, first held.
    apply(0, 2'b00, 2, 4'b0100, 0);
    n_vec++;
    check("stall_ready", 202, 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    check("stall_data", 202, 32'(out_data), 32'h44);
    check("stall_chan", 202, 32'(out_chan), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
